stage_fetch1: RTL and testbench



---
 rtl/stage_fetch1_pkg.sv | 13 +
 rtl/stage_fetch1.sv | 142 ++++++++++++++
 tb/tb_stage_fetch1.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stage_fetch1_pkg.sv
// Shared types and constants for the fetch1 stage.
package stage_fetch1_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWait  = 2'd1,
        StHold  = 2'd2,
        StDrain = 2'd3
    } fe1_state_t;

    localparam logic [31:0] FE1_FAULT_INSN = 32'h0;

endpackage

// File: rtl/stage_fetch1.sv
// Fetch1: tracks one outstanding icache access and hands the word (or fault) to decode.
// Optional performance counters are enabled with the FE1_PERF_EN macro.
module stage_fetch1
    import stage_fetch1_pkg::*;
#(
    parameter int unsigned PERF_W = 32
) (
    input  logic              clk_core,
    input  logic              reset_n,
    input  logic              fe0_valid,
    input  logic              fe0_specid,
    input  logic [29:0]       fe0_read_addr,
    output logic              fe1_stall,
    input  logic              icache_ready,
    input  logic [31:0]       icache_data,
    input  logic              icache_fault,
    input  logic              de_stall,
    input  logic              de_setpc,
    input  logic              csr_setpc,
    output logic              fe1_valid,
    output logic [29:0]       fe1_pc,
    output logic [31:0]       fe1_insn,
    output logic              fe1_specid,
    output logic              fe1_fault,
    output logic [PERF_W-1:0] fe1_perf_wait,
    output logic [PERF_W-1:0] fe1_perf_drain
);

    fe1_state_t  state_q, state_d;
    logic [29:0] pc_q, pc_d;
    logic        specid_q, specid_d;
    logic [31:0] buf_data_q, buf_data_d;
    logic        buf_fault_q, buf_fault_d;

    logic       flush;
    logic       accept;
    fe1_state_t nxt;
    logic       fault_sel;
    logic [31:0] insn_sel;

    always_comb begin
        flush       = de_setpc | csr_setpc;
        accept      = fe0_valid;
        nxt         = accept ? StWait : StIdle;
        state_d     = state_q;
        pc_d        = accept ? fe0_read_addr : pc_q;
        specid_d    = accept ? fe0_specid : specid_q;
        buf_data_d  = buf_data_q;
        buf_fault_d = buf_fault_q;

        unique case (state_q)
            StIdle: begin
                if (accept) state_d = StWait;
            end
            StWait: begin
                if (flush) begin
                    state_d = icache_ready ? nxt : StDrain;
                end else if (icache_ready) begin
                    if (de_stall) begin
                        state_d     = StHold;
                        buf_data_d  = icache_data;
                        buf_fault_d = icache_fault;
                    end else begin
                        state_d = nxt;
                    end
                end
            end
            StHold: begin
                if (flush || !de_stall) state_d = nxt;
            end
            StDrain: begin
                if (icache_ready) state_d = nxt;
            end
            default: state_d = StIdle;
        endcase
    end

    // Stall is deliberately independent of flush to avoid a loop through decode.
    always_comb begin
        fe1_stall  = ((state_q == StWait) && (!icache_ready || de_stall)) ||
                     ((state_q == StHold) && de_stall) ||
                     ((state_q == StDrain) && !icache_ready);
        fe1_valid  = ((state_q == StWait) && icache_ready) || (state_q == StHold);
        fault_sel  = (state_q == StHold) ? buf_fault_q : icache_fault;
        insn_sel   = (state_q == StHold) ? buf_data_q : icache_data;
        fe1_fault  = fault_sel;
        fe1_insn   = fault_sel ? FE1_FAULT_INSN : insn_sel;
        fe1_pc     = pc_q;
        fe1_specid = specid_q;
    end

    always_ff @(posedge clk_core) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            pc_q        <= '0;
            specid_q    <= 1'b0;
            buf_data_q  <= '0;
            buf_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            specid_q    <= specid_d;
            buf_data_q  <= buf_data_d;
            buf_fault_q <= buf_fault_d;
        end
    end

`ifdef FE1_PERF_EN
    logic [PERF_W-1:0] perf_wait_q, perf_wait_d;
    logic [PERF_W-1:0] perf_drain_q, perf_drain_d;

    always_comb begin
        perf_wait_d  = perf_wait_q;
        perf_drain_d = perf_drain_q;
        if ((state_q == StWait) && !icache_ready) perf_wait_d = perf_wait_q + 1'b1;
        if (state_q == StDrain) perf_drain_d = perf_drain_q + 1'b1;
    end

    always_ff @(posedge clk_core) begin
        if (!reset_n) begin
            perf_wait_q  <= '0;
            perf_drain_q <= '0;
        end else begin
            perf_wait_q  <= perf_wait_d;
            perf_drain_q <= perf_drain_d;
        end
    end

    assign fe1_perf_wait  = perf_wait_q;
    assign fe1_perf_drain = perf_drain_q;
`else
    assign fe1_perf_wait  = '0;
    assign fe1_perf_drain = '0;
`endif

`ifndef SYNTHESIS
    // A response with nothing outstanding means the icache broke the protocol.
    a_no_ready_in_idle: assert property (@(posedge clk_core) disable iff (!reset_n)
        !((state_q == StIdle) && icache_ready));
`endif

endmodule

// File: tb/tb_stage_fetch1.sv
// Scoreboard bench for stage_fetch1: expected words queued when the icache responds,
// popped when decode consumes them.
module tb_stage_fetch1;

    localparam int unsigned PERF_W = 32;

    logic              clk_core = 1'b0;
    logic              reset_n;
    logic              fe0_valid;
    logic              fe0_specid;
    logic [29:0]       fe0_read_addr;
    logic              fe1_stall;
    logic              icache_ready;
    logic [31:0]       icache_data;
    logic              icache_fault;
    logic              de_stall;
    logic              de_setpc;
    logic              csr_setpc;
    logic              fe1_valid;
    logic [29:0]       fe1_pc;
    logic [31:0]       fe1_insn;
    logic              fe1_specid;
    logic              fe1_fault;
    logic [PERF_W-1:0] fe1_perf_wait;
    logic [PERF_W-1:0] fe1_perf_drain;

    typedef struct packed {
        logic [29:0] pc;
        logic [31:0] insn;
        logic        fault;
        logic        specid;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk_core = ~clk_core;

    stage_fetch1 #(.PERF_W(PERF_W)) dut (
        .clk_core       (clk_core),
        .reset_n        (reset_n),
        .fe0_valid      (fe0_valid),
        .fe0_specid     (fe0_specid),
        .fe0_read_addr  (fe0_read_addr),
        .fe1_stall      (fe1_stall),
        .icache_ready   (icache_ready),
        .icache_data    (icache_data),
        .icache_fault   (icache_fault),
        .de_stall       (de_stall),
        .de_setpc       (de_setpc),
        .csr_setpc      (csr_setpc),
        .fe1_valid      (fe1_valid),
        .fe1_pc         (fe1_pc),
        .fe1_insn       (fe1_insn),
        .fe1_specid     (fe1_specid),
        .fe1_fault      (fe1_fault),
        .fe1_perf_wait  (fe1_perf_wait),
        .fe1_perf_drain (fe1_perf_drain)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge; everything is sampled on the falling edge.
    task automatic tick();
        @(posedge clk_core);
        #1;
    endtask

    task automatic quiet();
        fe0_valid     = 1'b0;
        fe0_specid    = 1'b0;
        fe0_read_addr = '0;
        icache_ready  = 1'b0;
        icache_data   = '0;
        icache_fault  = 1'b0;
        de_stall      = 1'b0;
        de_setpc      = 1'b0;
        csr_setpc     = 1'b0;
    endtask

    task automatic issue(input logic [29:0] addr, input logic sid);
        fe0_valid     = 1'b1;
        fe0_read_addr = addr;
        fe0_specid    = sid;
    endtask

    task automatic respond(input logic [29:0] pc, input logic sid, input logic [31:0] data,
                           input logic flt);
        exp_t e;
        icache_ready = 1'b1;
        icache_data  = data;
        icache_fault = flt;
        e.pc     = pc;
        e.insn   = flt ? 32'h0 : data;
        e.fault  = flt;
        e.specid = sid;
        sb_q.push_back(e);
    endtask

    task automatic sample();
        @(negedge clk_core);
    endtask

    // Consumption monitor: decode takes the word when valid and not stalled or redirecting.
    always @(negedge clk_core) begin
        if (reset_n === 1'b1 && fe1_valid === 1'b1 && !de_stall && !de_setpc && !csr_setpc)
        begin
            if (sb_q.size() == 0) begin
                check_eq("spurious_valid", 64'(fe1_pc), 64'h3fff_ffff);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_eq("sb_pc", 64'(fe1_pc), 64'(e.pc));
                check_eq("sb_insn", 64'(fe1_insn), 64'(e.insn));
                check_eq("sb_fault", 64'(fe1_fault), 64'(e.fault));
                check_eq("sb_specid", 64'(fe1_specid), 64'(e.specid));
            end
        end
    end

    initial begin
        quiet();
        reset_n = 1'b0;
        repeat (3) tick();
        sample();
        check_eq("rst_valid", 64'(fe1_valid), 64'h0);
        check_eq("rst_stall", 64'(fe1_stall), 64'h0);
        check_eq("rst_pc", 64'(fe1_pc), 64'h0);
        check_eq("rst_insn", 64'(fe1_insn), 64'h0);
        check_eq("rst_specid", 64'(fe1_specid), 64'h0);
        check_eq("rst_fault", 64'(fe1_fault), 64'h0);
        check_eq("rst_perf_wait", 64'(fe1_perf_wait), 64'h0);
        check_eq("rst_perf_drain", 64'(fe1_perf_drain), 64'h0);
        tick();
        reset_n = 1'b1;

        // Hit stream: one request per cycle, each answered the following cycle.
        for (int i = 0; i < 4; i++) begin
            quiet();
            if (i < 3) issue(30'h40 + 30'(i), 1'(i));
            if (i > 0) respond(30'h40 + 30'(i - 1), 1'(i - 1), 32'hA000_0000 + 32'(i), 1'b0);
            sample();
            check_eq("hit_stall", 64'(fe1_stall), 64'h0);
            check_eq("hit_valid", 64'(fe1_valid), (i > 0) ? 64'h1 : 64'h0);
            tick();
        end
        quiet();
        tick();

        // Miss: five cycles without a response, then the word arrives.
        issue(30'h80, 1'b0);
        tick();
        quiet();
        for (int i = 0; i < 5; i++) begin
            sample();
            check_eq("miss_stall", 64'(fe1_stall), 64'h1);
            check_eq("miss_valid", 64'(fe1_valid), 64'h0);
            tick();
        end
        respond(30'h80, 1'b0, 32'h0050_0093, 1'b0);
        sample();
        check_eq("miss_stall_rdy", 64'(fe1_stall), 64'h0);
        check_eq("miss_valid_rdy", 64'(fe1_valid), 64'h1);
        tick();
        quiet();
        tick();

        // Decode stall: the response is held in the buffer while icache_data moves on.
        issue(30'h90, 1'b1);
        tick();
        quiet();
        de_stall = 1'b1;
        respond(30'h90, 1'b1, 32'hDEAD_BEEF, 1'b0);
        sample();
        check_eq("hold_stall0", 64'(fe1_stall), 64'h1);
        tick();
        for (int i = 0; i < 2; i++) begin
            icache_ready = 1'b0;
            icache_data  = 32'h1111_1111;
            sample();
            check_eq("hold_insn", 64'(fe1_insn), 64'hDEAD_BEEF);
            check_eq("hold_valid", 64'(fe1_valid), 64'h1);
            check_eq("hold_stall", 64'(fe1_stall), 64'h1);
            tick();
        end
        de_stall = 1'b0;
        sample();
        check_eq("hold_release_stall", 64'(fe1_stall), 64'h0);
        tick();
        quiet();
        tick();

        // Redirect during a miss: the late response is discarded, a new request rides along.
        issue(30'hA0, 1'b0);
        tick();
        quiet();
        de_setpc = 1'b1;
        sample();
        check_eq("redir_stall", 64'(fe1_stall), 64'h1);
        tick();
        quiet();
        sample();
        check_eq("drain_stall", 64'(fe1_stall), 64'h1);
        check_eq("drain_valid", 64'(fe1_valid), 64'h0);
        tick();
        icache_ready = 1'b1;
        icache_data  = 32'hBAD0_BAD0;
        issue(30'hB0, 1'b1);
        sample();
        check_eq("drain_rdy_stall", 64'(fe1_stall), 64'h0);
        check_eq("drain_rdy_valid", 64'(fe1_valid), 64'h0);
        tick();
        quiet();
        respond(30'hB0, 1'b1, 32'h0000_0013, 1'b0);
        tick();
        quiet();
        tick();

        // Fault: instruction word is forced to zero.
        issue(30'hC0, 1'b1);
        tick();
        quiet();
        respond(30'hC0, 1'b1, 32'h1234_5678, 1'b1);
        sample();
        check_eq("fault_flag", 64'(fe1_fault), 64'h1);
        check_eq("fault_insn", 64'(fe1_insn), 64'h0);
        tick();
        quiet();
        tick();

        // Reset while a miss is outstanding.
        issue(30'hD0, 1'b1);
        tick();
        quiet();
        reset_n = 1'b0;
        tick();
        sample();
        check_eq("mrst_valid", 64'(fe1_valid), 64'h0);
        check_eq("mrst_stall", 64'(fe1_stall), 64'h0);
        check_eq("mrst_pc", 64'(fe1_pc), 64'h0);
        check_eq("mrst_specid", 64'(fe1_specid), 64'h0);
        tick();
        reset_n = 1'b1;
        tick();

        // Four waiting cycles (redirect on the last), then two cycles of drain.
        issue(30'hE0, 1'b0);
        tick();
        quiet();
        repeat (3) tick();
        csr_setpc = 1'b1;
        tick();
        quiet();
        tick();
        icache_ready = 1'b1;
        tick();
        quiet();
        sample();
        check_eq("post_drain_stall", 64'(fe1_stall), 64'h0);
`ifdef FE1_PERF_EN
        check_eq("perf_wait", 64'(fe1_perf_wait), 64'd4);
        check_eq("perf_drain", 64'(fe1_perf_drain), 64'd2);
`else
        check_eq("perf_wait", 64'(fe1_perf_wait), 64'd0);
        check_eq("perf_drain", 64'(fe1_perf_drain), 64'd0);
`endif
        tick();

        check_eq("sb_left", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
